// File: rtl/rd_xfr_controller_if.sv
// Handshake and status bundle between the RD transfer controller
// and its environment (trigger source, RD, processor).
interface rd_xfr_controller_if #(
   parameter int NBUF_BITS = 2
);
   logic                 ENABLE;
   logic                 TRIGGER;
   logic                 XFR_DONE;
   logic                 BUF_RELEASE;
   logic                 ERR_CLR;
   logic                 RD_TRIG;
   logic                 XFR_DONE_ACK;
   logic [NBUF_BITS-1:0] WR_BUF;
   logic [NBUF_BITS-1:0] RD_BUF;
   logic [NBUF_BITS:0]   FULL_COUNT;
   logic                 EVT_READY;
   logic                 BUSY;
   logic                 TIMEOUT_ERR;
   logic [15:0]          DROP_COUNT;

   modport master (
      input  ENABLE, TRIGGER, XFR_DONE, BUF_RELEASE, ERR_CLR,
      output RD_TRIG, XFR_DONE_ACK, WR_BUF, RD_BUF, FULL_COUNT,
      output EVT_READY, BUSY, TIMEOUT_ERR, DROP_COUNT
   );

   modport slave (
      output ENABLE, TRIGGER, XFR_DONE, BUF_RELEASE, ERR_CLR,
      input  RD_TRIG, XFR_DONE_ACK, WR_BUF, RD_BUF, FULL_COUNT,
      input  EVT_READY, BUSY, TIMEOUT_ERR, DROP_COUNT
   );
endinterface

// File: rtl/rd_xfr_controller.sv
// RD event transfer sequencer: trigger pulse, done/ack handshake,
// buffer ring bookkeeping, drop counting and transfer timeout.
module rd_xfr_controller #(
   parameter int NBUF_BITS   = 2,
   parameter int TRIG_WIDTH  = 8,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic                AXI_CLK,
   input  logic                AXI_RESETN,
   rd_xfr_controller_if.master bus
);
   localparam logic [NBUF_BITS-1:0] PTR_ONE = 1;
   localparam logic [NBUF_BITS:0]   CNT_ONE = 1;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_DONE,
      ACK,
      COMMIT
   } state_t;

   state_t               state, state_nx;
   logic [7:0]           wcnt, wcnt_nx;
   logic [23:0]          timer, timer_nx;
   logic                 timeout_set;
   logic [NBUF_BITS-1:0] wr_ptr, rd_ptr;
   logic [NBUF_BITS:0]   full_cnt, full_nx;
   logic                 evt_ready;
   logic                 timeout_err;
   logic [15:0]          drop_cnt;
   logic                 full;
   logic                 idle;
   logic                 accept;
   logic                 drop;
   logic                 commit;
   logic                 release_ok;

   // The count tops out at exactly 2**NBUF_BITS, so its MSB means full.
   assign full       = full_cnt[NBUF_BITS];
   assign idle       = (state == IDLE);
   assign accept     = bus.TRIGGER & bus.ENABLE & idle & ~full;
   assign drop       = bus.TRIGGER & bus.ENABLE & (~idle | full);
   assign commit     = (state == COMMIT);
   assign release_ok = bus.BUF_RELEASE & (full_cnt != '0);

   // State, trigger-width counter and done timer registers.
   always_ff @(posedge AXI_CLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) begin
         state <= IDLE;
         wcnt  <= '0;
         timer <= '0;
      end else begin
         state <= state_nx;
         wcnt  <= wcnt_nx;
         timer <= timer_nx;
      end
   end

   // Next-state logic for the transfer sequence.
   always_comb begin
      state_nx    = state;
      wcnt_nx     = wcnt;
      timer_nx    = timer;
      timeout_set = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nx = TRIG;
               wcnt_nx  = 8'(TRIG_WIDTH - 1);
            end
         end
         TRIG: begin
            if (wcnt == 8'd0) begin
               state_nx = WAIT_DONE;
               timer_nx = '0;
            end else begin
               wcnt_nx = wcnt - 8'd1;
            end
         end
         WAIT_DONE: begin
            if (bus.XFR_DONE) begin
               state_nx = ACK;
            end else if (timer == 24'(TIMEOUT_CYC)) begin
               state_nx    = IDLE;
               timeout_set = 1'b1;
            end else begin
               timer_nx = timer + 24'd1;
            end
         end
         ACK: begin
            if (!bus.XFR_DONE) state_nx = COMMIT;
         end
         COMMIT: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Fill level: a commit and a release in the same cycle cancel out.
   always_comb begin
      full_nx = full_cnt;
      if (commit && !release_ok) full_nx = full_cnt + CNT_ONE;
      if (!commit && release_ok) full_nx = full_cnt - CNT_ONE;
   end

   // Ring pointers, fill count and its registered non-empty flag.
   always_ff @(posedge AXI_CLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         full_cnt  <= '0;
         evt_ready <= 1'b0;
      end else begin
         if (commit) wr_ptr <= wr_ptr + PTR_ONE;
         if (release_ok) rd_ptr <= rd_ptr + PTR_ONE;
         full_cnt  <= full_nx;
         evt_ready <= (full_nx != '0);
      end
   end

   // Sticky error and saturating drop counter; a clear beats new events.
   always_ff @(posedge AXI_CLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) begin
         timeout_err <= 1'b0;
         drop_cnt    <= '0;
      end else if (bus.ERR_CLR) begin
         timeout_err <= 1'b0;
         drop_cnt    <= '0;
      end else begin
         if (timeout_set) timeout_err <= 1'b1;
         if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
   end

   assign bus.RD_TRIG      = (state == TRIG);
   assign bus.XFR_DONE_ACK = (state == ACK);
   assign bus.BUSY         = ~idle;
   assign bus.WR_BUF       = wr_ptr;
   assign bus.RD_BUF       = rd_ptr;
   assign bus.FULL_COUNT   = full_cnt;
   assign bus.EVT_READY    = evt_ready;
   assign bus.TIMEOUT_ERR  = timeout_err;
   assign bus.DROP_COUNT   = drop_cnt;
endmodule

// File: tb/tb_rd_xfr_controller.sv
// Testbench for rd_xfr_controller: directed scenarios plus a randomized
// sequence checked against a counting model of the buffer ring.
module tb_rd_xfr_controller;
   localparam int NB = 2;
   localparam int TW = 8;
   localparam int TO = 300;
   localparam int NBUF = 1 << NB;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   rd_xfr_controller_if #(.NBUF_BITS(NB)) bus ();

   rd_xfr_controller #(
      .NBUF_BITS(NB),
      .TRIG_WIDTH(TW),
      .TIMEOUT_CYC(TO)
   ) dut (
      .AXI_CLK(clk),
      .AXI_RESETN(rst_n),
      .bus(bus)
   );

   int vectors = 0;
   int miscompares = 0;

   // Model: counts of commits/releases; pointers are those counts mod NBUF.
   int m_full, m_wr, m_rd, m_drops;

   function automatic logic [27:0] all_outs();
      return {bus.RD_TRIG, bus.XFR_DONE_ACK, bus.WR_BUF, bus.RD_BUF,
              bus.FULL_COUNT, bus.EVT_READY, bus.BUSY, bus.TIMEOUT_ERR,
              bus.DROP_COUNT};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_full = 0;
      m_wr = 0;
      m_rd = 0;
      m_drops = 0;
   endtask

   task automatic model_drop();
      if (m_drops < 65535) m_drops++;
   endtask

   task automatic do_reset();
      bus.ENABLE = 1'b1;
      bus.TRIGGER = 1'b0;
      bus.XFR_DONE = 1'b0;
      bus.BUF_RELEASE = 1'b0;
      bus.ERR_CLR = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      model_clear();
   endtask

   // One complete transfer driven from the RD side, from IDLE.
   task automatic run_xfr(input int dly, input bit mid_trig,
                          input bit rel_commit, input bit en_low,
                          output int width, output bit ack_ok);
      int n;
      width = 0;
      ack_ok = 1'b1;
      bus.TRIGGER = 1'b1;
      tick();
      bus.TRIGGER = 1'b0;
      n = 0;
      while (bus.RD_TRIG && n < 300) begin
         width++;
         tick();
         n++;
      end
      if (en_low) bus.ENABLE = 1'b0;
      for (int i = 0; i < dly; i++) begin
         if (mid_trig && i == 0) bus.TRIGGER = 1'b1;
         tick();
         bus.TRIGGER = 1'b0;
      end
      if (mid_trig && dly > 0 && !en_low) model_drop();
      bus.XFR_DONE = 1'b1;
      n = 0;
      while (!bus.XFR_DONE_ACK && n < 20) begin
         tick();
         n++;
      end
      if (!bus.XFR_DONE_ACK) ack_ok = 1'b0;
      repeat ($urandom_range(0, 3)) begin
         tick();
         if (!bus.XFR_DONE_ACK) ack_ok = 1'b0;
      end
      bus.XFR_DONE = 1'b0;
      tick();
      if (bus.XFR_DONE_ACK || !bus.BUSY) ack_ok = 1'b0;
      if (rel_commit) bus.BUF_RELEASE = 1'b1;
      tick();
      bus.BUF_RELEASE = 1'b0;
      bus.ENABLE = 1'b1;
      if (bus.BUSY) ack_ok = 1'b0;
      m_wr++;
      if (rel_commit && m_full > 0) m_rd++;
      else m_full++;
   endtask

   task automatic pulse_release();
      bus.BUF_RELEASE = 1'b1;
      tick();
      bus.BUF_RELEASE = 1'b0;
      if (m_full > 0) begin
         m_full--;
         m_rd++;
      end
   endtask

   task automatic trig_attempt(input bit en);
      bus.ENABLE = en;
      bus.TRIGGER = 1'b1;
      tick();
      bus.TRIGGER = 1'b0;
      bus.ENABLE = 1'b1;
      if (en && m_full == NBUF) model_drop();
   endtask

   task automatic test_reset();
      bus.ENABLE = 1'b1;
      bus.TRIGGER = 1'b0;
      bus.XFR_DONE = 1'b0;
      bus.BUF_RELEASE = 1'b0;
      bus.ERR_CLR = 1'b0;
      rst_n = 1'b0;
      tick();
      vectors++;
      if (all_outs() !== 28'h0) begin
         miscompares++;
         $display("FAIL reset_outs got %h exp 0", all_outs());
      end
      rst_n = 1'b1;
      repeat (3) tick();
      vectors++;
      if (all_outs() !== 28'h0) begin
         miscompares++;
         $display("FAIL idle_outs got %h exp 0", all_outs());
      end
      model_clear();
   endtask

   task automatic test_single();
      int w;
      bit ok;
      do_reset();
      run_xfr(50, 1'b0, 1'b0, 1'b0, w, ok);
      vectors++;
      if (w !== TW) begin
         miscompares++;
         $display("FAIL t1_trig_width got %0d exp %0d", w, TW);
      end
      vectors++;
      if (ok !== 1'b1) begin
         miscompares++;
         $display("FAIL t1_ack_handshake got %0b exp 1", ok);
      end
      vectors++;
      if ({bus.WR_BUF, bus.FULL_COUNT, bus.EVT_READY} !== {2'd1, 3'd1, 1'b1}) begin
         miscompares++;
         $display("FAIL t1_state got wr=%0d full=%0d rdy=%0b exp 1 1 1",
                  bus.WR_BUF, bus.FULL_COUNT, bus.EVT_READY);
      end
   endtask

   task automatic test_fill();
      int w;
      bit ok;
      bit seen;
      do_reset();
      for (int i = 0; i < NBUF; i++) begin
         run_xfr($urandom_range(1, 60), 1'b0, 1'b0, 1'b0, w, ok);
      end
      vectors++;
      if ({bus.FULL_COUNT, bus.WR_BUF} !== {3'd4, 2'd0}) begin
         miscompares++;
         $display("FAIL t2_full got full=%0d wr=%0d exp 4 0",
                  bus.FULL_COUNT, bus.WR_BUF);
      end
      trig_attempt(1'b1);
      seen = 1'b0;
      repeat (3) begin
         if (bus.RD_TRIG || bus.BUSY) seen = 1'b1;
         tick();
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL t2_no_rd_trig got %0b exp 0", seen);
      end
      vectors++;
      if (bus.DROP_COUNT !== 16'd1) begin
         miscompares++;
         $display("FAIL t2_drop got %0d exp 1", bus.DROP_COUNT);
      end
      bus.ERR_CLR = 1'b1;
      bus.TRIGGER = 1'b1;
      tick();
      bus.ERR_CLR = 1'b0;
      bus.TRIGGER = 1'b0;
      m_drops = 0;
      vectors++;
      if (bus.DROP_COUNT !== 16'd0) begin
         miscompares++;
         $display("FAIL t2_clr_wins got %0d exp 0", bus.DROP_COUNT);
      end
   endtask

   task automatic test_drop_busy();
      int w;
      bit ok;
      do_reset();
      run_xfr(30, 1'b1, 1'b0, 1'b0, w, ok);
      vectors++;
      if ({bus.DROP_COUNT, bus.FULL_COUNT} !== {16'd1, 3'd1} || !ok) begin
         miscompares++;
         $display("FAIL t3_busy_drop got drop=%0d full=%0d ok=%0b exp 1 1 1",
                  bus.DROP_COUNT, bus.FULL_COUNT, ok);
      end
   endtask

   task automatic test_timeout();
      int cyc;
      int n;
      do_reset();
      bus.TRIGGER = 1'b1;
      tick();
      bus.TRIGGER = 1'b0;
      n = 0;
      while (bus.RD_TRIG && n < 300) begin
         tick();
         n++;
      end
      cyc = 0;
      while (!bus.TIMEOUT_ERR && cyc < TO + 50) begin
         tick();
         cyc++;
      end
      vectors++;
      if (cyc < TO || cyc > TO + 2) begin
         miscompares++;
         $display("FAIL t4_timeout_cycles got %0d exp %0d..%0d", cyc, TO, TO + 2);
      end
      vectors++;
      if ({bus.TIMEOUT_ERR, bus.BUSY, bus.WR_BUF, bus.FULL_COUNT}
          !== {1'b1, 1'b0, 2'd0, 3'd0}) begin
         miscompares++;
         $display("FAIL t4_state got err=%0b busy=%0b wr=%0d full=%0d exp 1 0 0 0",
                  bus.TIMEOUT_ERR, bus.BUSY, bus.WR_BUF, bus.FULL_COUNT);
      end
      bus.ERR_CLR = 1'b1;
      tick();
      bus.ERR_CLR = 1'b0;
      vectors++;
      if (bus.TIMEOUT_ERR !== 1'b0) begin
         miscompares++;
         $display("FAIL t4_err_clr got %0b exp 0", bus.TIMEOUT_ERR);
      end
   endtask

   task automatic test_release_commit();
      int w;
      bit ok;
      do_reset();
      run_xfr(5, 1'b0, 1'b0, 1'b0, w, ok);
      run_xfr(7, 1'b0, 1'b0, 1'b0, w, ok);
      run_xfr(9, 1'b0, 1'b1, 1'b0, w, ok);
      vectors++;
      if ({bus.FULL_COUNT, bus.RD_BUF, bus.WR_BUF} !== {3'd2, 2'd1, 2'd3}) begin
         miscompares++;
         $display("FAIL t5_coincident got full=%0d rd=%0d wr=%0d exp 2 1 3",
                  bus.FULL_COUNT, bus.RD_BUF, bus.WR_BUF);
      end
      pulse_release();
      pulse_release();
      pulse_release();
      tick();
      vectors++;
      if ({bus.FULL_COUNT, bus.RD_BUF, bus.EVT_READY} !== {3'd0, 2'd3, 1'b0}) begin
         miscompares++;
         $display("FAIL t5_empty_release got full=%0d rd=%0d rdy=%0b exp 0 3 0",
                  bus.FULL_COUNT, bus.RD_BUF, bus.EVT_READY);
      end
   endtask

   task automatic test_reset_mid();
      int w;
      bit ok;
      int n;
      do_reset();
      bus.TRIGGER = 1'b1;
      tick();
      bus.TRIGGER = 1'b0;
      n = 0;
      while (bus.RD_TRIG && n < 300) begin
         tick();
         n++;
      end
      bus.XFR_DONE = 1'b1;
      n = 0;
      while (!bus.XFR_DONE_ACK && n < 20) begin
         tick();
         n++;
      end
      vectors++;
      if (bus.XFR_DONE_ACK !== 1'b1) begin
         miscompares++;
         $display("FAIL t6_reach_ack got %0b exp 1", bus.XFR_DONE_ACK);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (all_outs() !== 28'h0) begin
         miscompares++;
         $display("FAIL t6_async_reset got %h exp 0", all_outs());
      end
      bus.XFR_DONE = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      model_clear();
      run_xfr(10, 1'b0, 1'b0, 1'b0, w, ok);
      vectors++;
      if ({bus.WR_BUF, bus.FULL_COUNT} !== {2'd1, 3'd1} || w !== TW) begin
         miscompares++;
         $display("FAIL t6_restart got wr=%0d full=%0d width=%0d exp 1 1 %0d",
                  bus.WR_BUF, bus.FULL_COUNT, w, TW);
      end
   endtask

   task automatic test_random();
      int w;
      bit ok;
      int r;
      do_reset();
      for (int it = 0; it < 60; it++) begin
         r = $urandom_range(0, 3);
         if (r <= 1) begin
            if (m_full == NBUF) begin
               trig_attempt(1'b1);
            end else begin
               run_xfr($urandom_range(1, 40), 1'($urandom % 2),
                       1'($urandom % 2), 1'($urandom % 2), w, ok);
               vectors++;
               if (w !== TW || ok !== 1'b1) begin
                  miscompares++;
                  $display("FAIL rnd_xfr it=%0d got width=%0d ok=%0b exp %0d 1",
                           it, w, ok, TW);
               end
            end
         end else if (r == 2) begin
            pulse_release();
         end else begin
            trig_attempt(1'b0);
         end
         tick();
         vectors++;
         if (bus.WR_BUF !== NB'(m_wr % NBUF) || bus.RD_BUF !== NB'(m_rd % NBUF)) begin
            miscompares++;
            $display("FAIL rnd_ptrs it=%0d got wr=%0d rd=%0d exp %0d %0d",
                     it, bus.WR_BUF, bus.RD_BUF, m_wr % NBUF, m_rd % NBUF);
         end
         vectors++;
         if (bus.FULL_COUNT !== 3'(m_full) || bus.EVT_READY !== (m_full != 0)) begin
            miscompares++;
            $display("FAIL rnd_full it=%0d got full=%0d rdy=%0b exp %0d %0b",
                     it, bus.FULL_COUNT, bus.EVT_READY, m_full, m_full != 0);
         end
         vectors++;
         if (bus.DROP_COUNT !== 16'(m_drops) || bus.BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL rnd_drop it=%0d got drop=%0d busy=%0b exp %0d 0",
                     it, bus.DROP_COUNT, bus.BUSY, m_drops);
         end
      end
   endtask

   initial begin
      #900us;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_drop_busy();
      test_timeout();
      test_release_commit();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
